uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Memory-mapped UART transmit controller on the wrapper's data bus (M_addr/M_WE/M_RE/M_WData/M_RData). It queues bytes written by the CPU or host into a small FIFO. It serialises them onto TxD as 8N1 frames using a baud divider. It exposes a status word for polling and mirrors the byte currently on the line in txd_buffer.

Parameters:
CLK_DIV, 87, clock cycles per UART bit (10 MHz / 115200); legal range 2..65535
DEPTH, 8, FIFO depth in bytes; power of two, at least 2
ADDR_DATA, 32'h0000002a, write address for transmit data
ADDR_STAT, 32'h0000002b, status read/clear address

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
M_addr  in  32  bus address
M_WE  in  1  bus write strobe, one cycle per access
M_RE  in  1  bus read strobe
M_WData  in  32  bus write data; only bits [7:0] are used for ADDR_DATA
M_RData  out  32  bus read data
TxD  out  1  serial output, idles high
txd_buffer  out  8  byte currently being shifted out (holds the last byte after completion)
busy  out  1  high while a frame is on the line or the FIFO is non-empty

Behaviour:
- Reset (async, active-high):
  - TxD=1, txd_buffer=0, busy=0, M_RData=0.
  - FIFO emptied, overflow flag cleared, FSM forced to IDLE, baud and bit counters cleared.
  - Reset mid-frame aborts the frame and drives TxD high immediately.
- Write path:
  - Sampled at the rising edge with M_WE=1 and M_addr==ADDR_DATA.
  - If FIFO not full: push M_WData[7:0]. If full: drop the byte and set sticky overflow.
  - A pop and a push in the same cycle on a full FIFO: both succeed and overflow is not set.
- Status: M_RData is combinational from M_addr.
  - For ADDR_STAT: {28'b0, overflow, full, empty, busy} (bit3..bit0).
  - For any other address: 0. M_RE does not gate the value and has no side effects.
  - A write to ADDR_STAT with M_WData[3]=1 clears overflow. If this coincides with an overflowing push, overflow stays set.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TxD=1. When the FIFO is non-empty at an edge: pop the head into the shift register and txd_buffer, then go to START. TxD becomes 0 at that same edge.
  - START: TxD=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: TxD=shift[bit index], LSB first, CLK_DIV cycles per bit. After bit 7, go to STOP.
  - STOP: TxD=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Timing:
  - Frame length is exactly 10*CLK_DIV cycles.
  - A write at edge N into an empty, idle controller makes TxD fall at edge N+1.
- Counters:
  - Baud counter width is clog2(CLK_DIV). It reloads to 0 on every bit boundary and on every pop.
  - FIFO pointers are clog2(DEPTH)+1 bits, with wrap-around by natural overflow. full/empty are derived from pointer compare.
- busy = (state != IDLE) | !empty.
- Capacity while the line is busy: DEPTH bytes queued plus 1 in the shifter.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - default address constants ADDR_DATA and ADDR_STAT
  - status bit indices STAT_BUSY=0, STAT_EMPTY=1, STAT_FULL=2, STAT_OVF=3
- Sub-module sync_fifo (WIDTH=8, DEPTH):
  - push/pop/din/dout/full/empty
  - first-word-fall-through, async reset
  - permits simultaneous push and pop when full

Test Plan (CLK_DIV=4, DEPTH=8):
- Single byte: after reset release, write 32'hcafebabe to 0x2a.
  - TxD falls one edge later. Bit sequence, 4 cycles each: 0 | 0,1,1,1,1,1,0,1 | 1.
  - txd_buffer=8'hBE. busy drops exactly 40 cycles after TxD fell.
- Back-to-back: write 8'h55 then 8'hA3 on consecutive cycles.
  - Two frames occur with no idle cycle between the stop bit of 0x55 and the start bit of 0xA3.
  - Status reads 4'b0001 during transmission and 4'b0010 afterwards.
- Overflow: write 10 bytes on consecutive cycles.
  - The first 9 bytes are transmitted in order; the 10th is dropped.
  - Status bit3=1 from that cycle on. Writing 32'h8 to 0x2b clears bit3.
- Full plus pop: fill the FIFO during a frame, then write on the exact edge where STOP ends.
  - The byte is accepted and overflow remains 0.
- Reset mid-frame: assert reset during DATA bit 3.
  - TxD=1 and busy=0 immediately (asynchronously). Status reads 4'b0010.
  - No further frames follow after release.
- Address decode: write to 0x2c with M_WE=1. No frame starts, and M_RData=0 for addresses other than 0x2b.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller: FSM states,
// default bus addresses and the status word layout.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic [31:0] ADDR_DATA = 32'h0000_002a;
  localparam logic [31:0] ADDR_STAT = 32'h0000_002b;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;

  function automatic logic [3:0] pack_status(input logic ovf, input logic full,
                                             input logic empty, input logic busy);
    logic [3:0] s;
    s            = '0;
    s[STAT_OVF]   = ovf;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_BUSY]  = busy;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// CPU data bus plus serial-line observation signals of the UART transmitter.
// master = bus initiator / observer, slave = the controller.
interface uart_tx_ctrl_if;
  logic [31:0] M_addr;
  logic        M_WE;
  logic        M_RE;
  logic [31:0] M_WData;
  logic [31:0] M_RData;
  logic        TxD;
  logic [7:0]  txd_buffer;
  logic        busy;

  modport master (
    output M_addr, M_WE, M_RE, M_WData,
    input  M_RData, TxD, txd_buffer, busy
  );

  modport slave (
    input  M_addr, M_WE, M_RE, M_WData,
    output M_RData, TxD, txd_buffer, busy
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; push/pop take effect at the clock edge, dout shows the head.
// Push on full is ignored unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter: bus writes queue bytes, TxD falls one edge after
// the first write; a full FIFO drops writes and sets a sticky overflow flag.
module uart_tx_ctrl #(
  parameter int          CLK_DIV   = 87,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] ADDR_DATA = uart_pkg::ADDR_DATA,
  parameter logic [31:0] ADDR_STAT = uart_pkg::ADDR_STAT
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_ctrl_if.slave  bus
);
  import uart_pkg::*;

  localparam int          BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    txbuf_q;
  logic          txd_q;
  logic          ovf_q;
  logic          ovf_d;

  logic          push_req;
  logic          stat_wr;
  logic          baud_last;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic          busy;
  logic [3:0]    status;
  logic          unused_bits;

  assign push_req  = bus.M_WE && (bus.M_addr == ADDR_DATA);
  assign stat_wr   = bus.M_WE && (bus.M_addr == ADDR_STAT);
  assign baud_last = (baud_q == BAUD_LAST);
  // The head is taken either from idle or exactly at the end of a stop bit.
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && baud_last));

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (bus.M_WData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A set from a dropped byte wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_wr && bus.M_WData[STAT_OVF]) ovf_d = 1'b0;
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txbuf_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          txd_q  <= 1'b1;
          if (fifo_pop) begin
            shift_q <= fifo_dout;
            txbuf_q <= fifo_dout;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= shift_q[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (fifo_pop) begin
              shift_q <= fifo_dout;
              txbuf_q <= fifo_dout;
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign busy   = (state_q != IDLE) || !fifo_empty;
  assign status = pack_status(ovf_q, fifo_full, fifo_empty, busy);

  assign bus.M_RData    = (bus.M_addr == ADDR_STAT) ? {28'b0, status} : 32'b0;
  assign bus.TxD        = txd_q;
  assign bus.txd_buffer = txbuf_q;
  assign bus.busy       = busy;

  // Reads have no side effects and only the low data byte is ever stored.
  assign unused_bits = ^{bus.M_RE, bus.M_WData[31:8]};

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame-position reference model, line receiver and literal checks.
module tb_uart_tx_ctrl;
  localparam int D     = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_ctrl_if bus();

  uart_tx_ctrl #(.CLK_DIV(D), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queued bytes plus position within the current 10*D-cycle frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  bit         m_act;
  int         m_pos;
  bit         m_ovf;
  bit         m_pop, m_full, m_wd, m_ws;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_act = 0; m_pos = 0; m_cur = 8'h00; m_ovf = 0;
    end else begin
      m_full = (m_q.size() == DEPTH);
      m_pop  = 0;
      if (m_act) begin
        m_pos++;
        if (m_pos == 10 * D) begin
          m_act = 0;
          if (m_q.size() > 0) begin m_pop = 1; m_act = 1; m_pos = 0; end
        end
      end else if (m_q.size() > 0) begin
        m_pop = 1; m_act = 1; m_pos = 0;
      end
      m_wd = bus.M_WE && (bus.M_addr == 32'h2a);
      m_ws = bus.M_WE && (bus.M_addr == 32'h2b);
      if (m_pop) m_cur = m_q.pop_front();
      if (m_wd) begin
        if (!m_full || m_pop) m_q.push_back(bus.M_WData[7:0]);
        else m_ovf = 1;
      end
      if (m_ws && bus.M_WData[3]) m_ovf = 0;
    end
  end

  function automatic logic exp_txd();
    int k;
    if (!m_act) return 1'b1;
    k = m_pos / D;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  function automatic logic exp_busy();
    return m_act || (m_q.size() > 0);
  endfunction

  function automatic logic [3:0] exp_stat();
    return {m_ovf, m_q.size() == DEPTH, m_q.size() == 0, exp_busy()};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("model_txd", bus.TxD, exp_txd());
      check("model_txd_buffer", bus.txd_buffer, m_cur);
      check("model_busy", bus.busy, exp_busy());
      check("model_rdata", bus.M_RData,
            (bus.M_addr == 32'h2b) ? {28'b0, exp_stat()} : 32'h0);
    end
  end

  // Line receiver: samples mid-bit and collects decoded bytes.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh;
  bit         rx_busy;
  int         rx_cnt;
  int         rx_k;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      rx_busy = 0; rx_cnt = 0;
    end else if (!rx_busy) begin
      if (bus.TxD === 1'b0) begin rx_busy = 1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt % D == D / 2) begin
        rx_k = rx_cnt / D;
        if (rx_k >= 1 && rx_k <= 8) rx_sh[rx_k-1] = bus.TxD;
        else if (rx_k == 9) begin
          check("rx_stop_bit", bus.TxD, 1);
          rx_q.push_back(rx_sh);
          rx_busy = 0;
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.M_addr  = a;
    bus.M_WData = d;
    bus.M_WE    = 1'b1;
    @(posedge clk); #1;
    bus.M_WE    = 1'b0;
  endtask

  task automatic check_rx(input string name, input int base, input int n);
    check({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check({name, "_byte"}, rx_q[i], base + i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  logic [9:0] pat;

  initial begin
    bus.M_addr = 32'h0; bus.M_WE = 1'b0; bus.M_RE = 1'b0; bus.M_WData = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    bus.M_addr = 32'h2b; #1;
    check("reset_txd", bus.TxD, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_txd_buffer", bus.txd_buffer, 8'h00);
    check("reset_status", bus.M_RData, 32'h2);
    bus.M_addr = 32'h0; #1;
    check("reset_rdata_other", bus.M_RData, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single byte 0xBE
    rx_q.delete();
    wr(32'h2a, 32'hcafebabe);
    @(negedge clk);
    check("single_not_early", bus.TxD, 1);
    pat = 10'b1_1011_1110_0;
    for (int i = 0; i < 10 * D; i++) begin
      @(negedge clk);
      check("single_frame_bit", bus.TxD, pat[i / D]);
      if (i == 10 * D - 1) check("single_busy_last", bus.busy, 1);
    end
    check("single_txd_buffer", bus.txd_buffer, 8'hbe);
    @(negedge clk);
    check("single_busy_drop", bus.busy, 0);
    check_rx("single_rx", 8'hbe, 1);
    @(posedge clk); #1;

    // Back-to-back 0x55, 0xA3
    rx_q.delete();
    wr(32'h2a, 32'h55);
    wr(32'h2a, 32'ha3);
    bus.M_addr = 32'h2b;
    @(negedge clk);
    check("b2b_status_busy", bus.M_RData, 32'h1);
    repeat (39) @(posedge clk);
    @(negedge clk);
    check("b2b_stop_55", bus.TxD, 1);
    @(negedge clk);
    check("b2b_start_no_gap", bus.TxD, 0);
    check("b2b_txd_buffer", bus.txd_buffer, 8'ha3);
    repeat (45) @(negedge clk);
    check("b2b_status_done", bus.M_RData, 32'h2);
    check("b2b_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("b2b_rx_first", rx_q[0], 8'h55);
      check("b2b_rx_second", rx_q[1], 8'ha3);
    end
    @(posedge clk); #1;

    // Overflow: 10 writes, the 10th dropped
    rx_q.delete();
    for (int i = 0; i < 10; i++) wr(32'h2a, 32'h10 + i);
    bus.M_addr = 32'h2b;
    @(negedge clk);
    check("ovf_status_set", bus.M_RData, 32'hd);
    repeat (9 * 10 * D + 10) @(negedge clk);
    check_rx("ovf_rx", 8'h10, 9);
    check("ovf_status_sticky", bus.M_RData, 32'ha);
    @(posedge clk); #1;
    wr(32'h2b, 32'h8);
    bus.M_addr = 32'h2b;
    @(negedge clk);
    check("ovf_cleared", bus.M_RData, 32'h2);
    @(posedge clk); #1;

    // Full FIFO plus push on the stop-end pop edge
    rx_q.delete();
    for (int i = 0; i < 9; i++) wr(32'h2a, 32'h20 + i);
    repeat (32) @(posedge clk); #1;
    bus.M_addr = 32'h2b; #1;
    check("fullpop_full_before", bus.M_RData, 32'h5);
    wr(32'h2a, 32'h29);
    bus.M_addr = 32'h2b;
    @(negedge clk);
    check("fullpop_no_ovf", bus.M_RData, 32'h5);
    repeat (10 * 10 * D + 10) @(negedge clk);
    check_rx("fullpop_rx", 8'h20, 10);
    check("fullpop_status_done", bus.M_RData, 32'h2);
    @(posedge clk); #1;

    // Reset during data bit 3
    rx_q.delete();
    wr(32'h2a, 32'h00);
    wr(32'h2a, 32'h81);
    bus.M_addr = 32'h2b;
    repeat (17) @(posedge clk);
    #1;
    check("rst_bit3_low", bus.TxD, 0);
    #1 reset = 1'b1;
    #1;
    check("rst_txd_high", bus.TxD, 1);
    check("rst_busy_low", bus.busy, 0);
    check("rst_status", bus.M_RData, 32'h2);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("rst_no_frames", rx_q.size(), 0);
    check("rst_line_idle", bus.TxD, 1);
    @(posedge clk); #1;

    // Address decode
    wr(32'h2c, 32'hff);
    bus.M_addr = 32'h2c;
    repeat (10) @(negedge clk);
    check("dec_no_busy", bus.busy, 0);
    check("dec_line_idle", bus.TxD, 1);
    check("dec_rdata_2c", bus.M_RData, 32'h0);
    bus.M_addr = 32'h2a; bus.M_RE = 1'b1; #1;
    check("dec_rdata_2a", bus.M_RData, 32'h0);
    bus.M_addr = 32'h0; #1;
    check("dec_rdata_0", bus.M_RData, 32'h0);
    bus.M_addr = 32'h2b; #1;
    check("dec_rdata_stat", bus.M_RData, 32'h2);
    bus.M_RE = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
